// File: rtl/auto_nav.sv
// auto_nav: wall-following command source that drives the one-hot move_* lines when the controller waits at a junction.
//   clk, rst_n            : 500 Hz clock, asynchronous active-low reset
//   enable                : automatic mode; low forces IDLE on the next edge
//   detector[3:0]         : {front, back, left, right}, 1 = blocked
//   semi_state[2:0]       : controller state, WAITING_CODE means waiting at a junction
//   move_forward/left/right/backward : one-hot command, high only in ISSUE
//   stuck                 : high while every direction is blocked
//   nav_state[2:0]        : IDLE=0 SETTLE=1 ISSUE=2 BUSY=3 STUCK=4
//   AUTO_NAV_RIGHT_HAND_EN: when defined, the priority is right, forward, left, back;
//                           otherwise it is left, forward, right, back
module auto_nav #(
  parameter int SETTLE_CYCLES = 25,
  parameter int ISSUE_TIMEOUT = 10,
  parameter logic [2:0] WAITING_CODE = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] detector,
  input  logic [2:0] semi_state,
  output logic       move_forward,
  output logic       move_left,
  output logic       move_right,
  output logic       move_backward,
  output logic       stuck,
  output logic [2:0] nav_state
);
  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, BUSY, STUCK} state_t;
  state_t state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d, issue_cnt_q, issue_cnt_d;
  logic [3:0] det_q, choice_q, choice_d, pick;
  logic waiting;
  assign waiting = semi_state == WAITING_CODE;
  // pick is one-hot {forward, left, right, backward}; a blocked direction is never chosen
`ifdef AUTO_NAV_RIGHT_HAND_EN
  assign pick = !detector[0] ? 4'b0010 : !detector[3] ? 4'b1000 :
                !detector[1] ? 4'b0100 : !detector[2] ? 4'b0001 : 4'b0000;
`else
  assign pick = !detector[1] ? 4'b0100 : !detector[3] ? 4'b1000 :
                !detector[0] ? 4'b0010 : !detector[2] ? 4'b0001 : 4'b0000;
`endif
  always_comb begin
    state_d = state_q;
    settle_cnt_d = 8'd0;
    issue_cnt_d = 8'd0;
    choice_d = choice_q;
    if (!enable) begin
      state_d = IDLE;
      choice_d = 4'b0000;
    end else begin
      case (state_q)
        IDLE:   if (waiting) state_d = SETTLE;
        SETTLE:
          if (!waiting) state_d = BUSY;
          // a detector change restarts the settle window, even on the terminal cycle
          else if (detector != det_q) settle_cnt_d = 8'd0;
          else if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
            if (detector == 4'b1111) state_d = STUCK;
            else begin
              state_d = ISSUE;
              choice_d = pick;
            end
          end else settle_cnt_d = settle_cnt_q + 8'd1;
        ISSUE:
          if (!waiting) state_d = BUSY;
          else if (issue_cnt_q == 8'(ISSUE_TIMEOUT - 1)) state_d = SETTLE;
          else issue_cnt_d = issue_cnt_q + 8'd1;
        BUSY:   if (waiting) state_d = SETTLE;
        STUCK:  if (detector != 4'b1111) state_d = SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      settle_cnt_q <= 8'd0;
      issue_cnt_q <= 8'd0;
      det_q <= 4'b0000;
      choice_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      settle_cnt_q <= settle_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      det_q <= detector;
      choice_q <= choice_d;
    end
  end
  assign {move_forward, move_left, move_right, move_backward} = (state_q == ISSUE) ? choice_q : 4'b0000;
  assign stuck = state_q == STUCK;
  assign nav_state = state_q;
endmodule
